// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: digit count,
// segment encoding helpers and the packed display-output bundle.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;
  localparam int SEG_W      = 7;

  // Segment pattern with every segment dark (active-high encoding).
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  typedef logic [SEG_W-1:0] seg_t;

  // One display update: digit enables, segments {g,f,e,d,c,b,a}, decimal point.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    seg_t                  seg;
    logic                  dp;
  } disp_t;

  localparam int DISP_W = $bits(disp_t);

  // Hex nibble to active-high segment pattern, bit0 = segment a.
  function automatic seg_t hex2seg(input logic [NIBBLE_W-1:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit to seven-segment decoder (active-high, bit0 = a).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [SEG_W-1:0]    seg_o
);

  assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit hex display driver. A prescaler sets the slot
// length, the digit index walks 0..7, and the displayed word is latched
// only at the frame boundary so a frame never mixes two input words.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] data_in,
  input  logic                         en,
  input  logic                         blank_lz,
  input  logic [NUM_DIGITS-1:0]        dp_mask,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp,
  output logic                         frame_done
);

  localparam int WORD_W = NUM_DIGITS * NIBBLE_W;
  localparam int PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CYC);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  // XOR mask applied to the active-high display bundle; also the idle value.
  localparam logic [DISP_W-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic              frame_done_q, frame_done_d;
  disp_t             disp_q, disp_d;

  logic              pcnt_wrap;
  logic              frame_end;
  logic [NIBBLE_W-1:0] cur_nibble;
  seg_t              cur_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic              lit;
  disp_t             disp_act;

  assign pcnt_wrap = (pcnt_q == PCNT_LAST);
  assign frame_end = pcnt_wrap && (idx_q == IDX_LAST);

  // Next-state for the prescaler, digit index, shadow word and frame pulse.
  always_comb begin
    pcnt_d       = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    idx_d        = pcnt_wrap ? idx_q + 3'd1 : idx_q;
    shadow_d     = frame_end ? data_in : shadow_q;
    frame_done_d = frame_end;
  end

  // A digit is a leading zero when it and every more significant nibble are
  // zero; the rightmost digit always stays visible so zero still reads "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz && (shadow_q[WORD_W-1:gi*NIBBLE_W] == '0);
      end
    end
  endgenerate

  assign cur_nibble = shadow_q[NIBBLE_W*idx_q +: NIBBLE_W];

  seg7_hex_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // The first BLANK_CYC cycles of each slot stay dark so the previous
  // digit's segments never ghost onto the newly enabled anode.
  assign lit = en && (pcnt_q >= PCNT_BLANK) && !lz_blank[idx_q];

  // Active-high view of the display for the current slot.
  always_comb begin
    disp_act.an  = '0;
    disp_act.seg = SEG_OFF;
    disp_act.dp  = 1'b0;
    if (lit) begin
      disp_act.an  = NUM_DIGITS'(1) << idx_q;
      disp_act.seg = cur_seg;
      disp_act.dp  = dp_mask[idx_q];
    end
  end

  // Apply output polarity ahead of the output registers.
  always_comb begin
    disp_d = disp_t'(disp_act ^ POL_MASK);
  end

  // State and output registers; reset returns every output to its inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      disp_q       <= disp_t'(POL_MASK);
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      disp_q       <= disp_d;
    end
  end

  assign an         = disp_q.an;
  assign seg        = disp_q.seg;
  assign dp         = disp_q.dp;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: a cycle-level reference model compares
// every output on every cycle, plus table vectors and hand-written sequences.
module tb_seg7_scan;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int AL    = 1;
  localparam int FRAME = 8 * RD;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .en         (en),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Time since reset release determines slot position; shadow is the word
  // present on data_in at the last cycle of each frame.
  int          m_t = 0;
  logic [31:0] m_shadow = '0;
  logic [15:0] m_exp = 16'hFFFF;
  logic        m_fd = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [15:0] ref_disp(int pc, int ix, logic [31:0] sh,
                                           logic e, logic lz, logic [7:0] dpm);
    logic [7:0] a;
    logic [6:0] s;
    logic       d;
    logic [31:0] above;
    bit blanked;
    a = 8'h00; s = 7'h00; d = 1'b0;
    above = sh >> (4 * ix);
    blanked = lz && (ix >= 1) && (above == 0);
    if (e && (pc >= BC) && !blanked) begin
      a[ix] = 1'b1;
      s = HEX[above & 32'hF];
      d = dpm[ix];
    end
    return ~{a, s, d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_shadow = '0; m_exp = 16'hFFFF; m_fd = 1'b0; m_valid = 1'b1;
    end else begin
      m_exp = ref_disp(m_t % RD, (m_t / RD) % 8, m_shadow, en, blank_lz, dp_mask);
      m_fd  = ((m_t % FRAME) == FRAME - 1);
      if (m_fd) m_shadow = data_in;
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({an, seg, dp} !== m_exp || frame_done !== m_fd) begin
        errors++;
        $display("FAIL model t=%0d: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                 m_t, an, seg, dp, frame_done, m_exp[15:8], m_exp[7:1], m_exp[0], m_fd);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where frame_done is seen (frame offset 0).
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 4 * FRAME);
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL wait_fd: got no pulse in %0d cycles want pulse", n);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        e;
    logic        lz;
    logic [7:0]  dpm;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    int n;

    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 0, 8'hFE, 7'h21, 1'b1});
    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 7, 8'h7F, 7'h79, 1'b1});
    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 3, 8'hF7, 7'h08, 1'b1});
    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 1, 8'hFD, 7'h46, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 1'b1, 8'h00, 1, 8'hFD, 7'h08, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 1'b1, 8'h00, 0, 8'hFE, 7'h40, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 1'b1, 8'h00, 2, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 1'b1, 8'h00, 7, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h00000000, 1'b1, 1'b1, 8'h00, 0, 8'hFE, 7'h40, 1'b1});
    vecs.push_back('{32'h00000000, 1'b1, 1'b1, 8'h00, 5, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h00000000, 1'b1, 1'b0, 8'h00, 5, 8'hDF, 7'h40, 1'b1});
    vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 8'h00, 2, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h10, 4, 8'hEF, 7'h19, 1'b0});
    vecs.push_back('{32'h1234ABCD, 1'b1, 1'b0, 8'h10, 3, 8'hF7, 7'h08, 1'b1});
    vecs.push_back('{32'h89EF5670, 1'b1, 1'b1, 8'h00, 7, 8'h7F, 7'h00, 1'b1});
    vecs.push_back('{32'h89EF5670, 1'b1, 1'b1, 8'h00, 6, 8'hBF, 7'h10, 1'b1});
    vecs.push_back('{32'h89EF5670, 1'b1, 1'b1, 8'h00, 5, 8'hDF, 7'h06, 1'b1});
    vecs.push_back('{32'h89EF5670, 1'b1, 1'b1, 8'h00, 4, 8'hEF, 7'h0E, 1'b1});
    vecs.push_back('{32'h89EF5670, 1'b1, 1'b1, 8'hFF, 0, 8'hFE, 7'h40, 1'b0});
    vecs.push_back('{32'h0000B000, 1'b1, 1'b1, 8'h00, 3, 8'hF7, 7'h03, 1'b1});
    vecs.push_back('{32'h0000B000, 1'b1, 1'b1, 8'h00, 4, 8'hFF, 7'h7F, 1'b1});

    // 1. Reset values, then the first frame shows all zeros.
    rst = 1'b1; data_in = 32'hDEADBEEF; en = 1'b1; blank_lz = 1'b0; dp_mask = 8'h00;
    negs(3);
    chk("reset_an", {24'h0, an}, 32'hFF);
    chk("reset_seg", {25'h0, seg}, 32'h7F);
    chk("reset_dp", {31'h0, dp}, 32'h1);
    chk("reset_fd", {31'h0, frame_done}, 32'h0);
    rst = 1'b0;
    pos = 0;
    for (int d = 0; d < 8; d++) begin
      negs(d * RD + BC + 1 - pos);
      pos = d * RD + BC + 1;
      chk($sformatf("first_frame_an%0d", d), {24'h0, an}, {24'h0, ~(8'h01 << d)});
      chk($sformatf("first_frame_seg%0d", d), {25'h0, seg}, 32'h40);
    end
    $display("first frame after reset checked");

    // 2/3. Table vectors: data latched at a frame edge, then one slot probed.
    foreach (vecs[i]) begin
      data_in = vecs[i].data; en = vecs[i].e; blank_lz = vecs[i].lz; dp_mask = vecs[i].dpm;
      wait_fd();
      negs(vecs[i].digit * RD + 1);
      chk($sformatf("vec%0d_blank_an", i), {24'h0, an}, 32'hFF);
      negs(BC);
      chk($sformatf("vec%0d_an", i), {24'h0, an}, {24'h0, vecs[i].an});
      chk($sformatf("vec%0d_seg", i), {25'h0, seg}, {25'h0, vecs[i].seg});
      chk($sformatf("vec%0d_dp", i), {31'h0, dp}, {31'h0, vecs[i].dp});
      $display("vec %0d: data=%h digit %0d an=%h seg=%h dp=%b", i, vecs[i].data,
               vecs[i].digit, an, seg, dp);
    end

    // 4. No tearing: a mid-frame data change waits for the frame edge.
    en = 1'b1; blank_lz = 1'b0; dp_mask = 8'h00; data_in = 32'h11111111;
    wait_fd();
    negs(3 * RD + BC + 1);
    data_in = 32'h22222222;
    for (int d = 4; d < 8; d++) begin
      negs(RD);
      chk($sformatf("tear_old_seg%0d", d), {25'h0, seg}, 32'h79);
    end
    wait_fd();
    pos = 0;
    for (int d = 0; d < 8; d++) begin
      negs(d * RD + BC + 1 - pos);
      pos = d * RD + BC + 1;
      chk($sformatf("tear_new_seg%0d", d), {25'h0, seg}, 32'h24);
    end
    $display("tearing sequence checked");

    // 5. Disable for two frames: anodes stay off, frame pulse keeps its period.
    en = 1'b0;
    wait_fd();
    for (int f = 0; f < 2; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        chk("disabled_an", {24'h0, an}, 32'hFF);
      end while (!frame_done && n < 4 * FRAME);
      chk($sformatf("frame_period%0d", f), n, FRAME);
    end
    en = 1'b1; dp_mask = 8'h10; data_in = 32'h1234ABCD;
    wait_fd();
    pos = 0;
    for (int d = 0; d < 8; d++) begin
      negs(d * RD + BC + 1 - pos);
      pos = d * RD + BC + 1;
      chk($sformatf("dp_slot%0d", d), {31'h0, dp}, (d == 4) ? 32'h0 : 32'h1);
    end
    $display("disable and dp sequence checked");

    // 6. Reset during digit 5: reset values next edge, scan restarts at digit 0.
    dp_mask = 8'h00;
    wait_fd();
    negs(5 * RD + 4);
    rst = 1'b1;
    negs(1);
    chk("midrst_an", {24'h0, an}, 32'hFF);
    chk("midrst_seg", {25'h0, seg}, 32'h7F);
    chk("midrst_dp", {31'h0, dp}, 32'h1);
    chk("midrst_fd", {31'h0, frame_done}, 32'h0);
    rst = 1'b0;
    negs(BC + 1);
    chk("midrst_restart_an", {24'h0, an}, 32'hFE);
    chk("midrst_restart_seg", {25'h0, seg}, 32'h40);
    n = BC + 1;
    while (!frame_done && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_first_frame_len", n, FRAME);
    $display("mid-frame reset sequence checked");

    // Randomized stimulus, checked cycle by cycle by the reference model.
    for (int c = 0; c < 12 * FRAME; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 15))
        0: data_in = $urandom >> (4 * $urandom_range(0, 8));
        1: en = $urandom_range(0, 7) != 0;
        2: blank_lz = $urandom_range(0, 1) != 0;
        3: dp_mask = 8'($urandom);
        default: ;
      endcase
    end
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
